wb_cmd_master: RTL and testbench

//  Single-outstanding Wishbone (pipelined) bus master that sits directly upstream of our wishbone slaves.
//  - Turns a simple valid/ready command stream (host/debug/controller side) into one Wishbone transaction.
//  - Returns the outcome on a valid/ready response stream: read data, bus error, or timeout.
//  - Bounds every transaction with a timeout, so a dead slave cannot hang the bus.

---
 rtl/wb_cmd_master_if.sv | 39 +++
 rtl/wb_cmd_master.sv | 77 +++++++
 tb/tb_wb_cmd_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command, response and Wishbone bus signals of wb_cmd_master
interface wb_cmd_master_if #(
    parameter int AW = 2,
    parameter int DW = 32
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic          i_wb_err;
    logic [DW-1:0] i_wb_data;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready,
               i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready,
               i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding pipelined Wishbone master with transaction timeout
module wb_cmd_master #(
    parameter int AW = 2,
    parameter int DW = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic i_clk,
    input logic i_reset,
    wb_cmd_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic done, tmo;
    assign done = bus.i_wb_ack || bus.i_wb_err;
    assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    // Accept a command, run one bus cycle bounded by the timeout, then hold the response until taken
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            bus.o_cmd_ready <= 1'b0;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_data <= {DW{1'b0}};
            bus.o_rsp_err <= 1'b0;
            bus.o_rsp_timeout <= 1'b0;
            bus.o_wb_cyc <= 1'b0;
            bus.o_wb_stb <= 1'b0;
            bus.o_wb_we <= 1'b0;
            bus.o_wb_addr <= {AW{1'b0}};
            bus.o_wb_data <= {DW{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                        bus.o_cmd_ready <= 1'b0;
                        bus.o_wb_cyc <= 1'b1;
                        bus.o_wb_stb <= 1'b1;
                        bus.o_wb_we <= bus.i_cmd_we;
                        bus.o_wb_addr <= bus.i_cmd_addr;
                        bus.o_wb_data <= bus.i_cmd_data;
                        cnt <= '0;
                        state <= REQ;
                    end else begin
                        bus.o_cmd_ready <= 1'b1;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done || tmo) begin
                        state <= RESP;
                        bus.o_wb_cyc <= 1'b0;
                        bus.o_wb_stb <= 1'b0;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err <= bus.i_wb_err || !bus.i_wb_ack;
                        bus.o_rsp_timeout <= !done;
                        bus.o_rsp_data <= (bus.i_wb_ack && !bus.i_wb_err && !bus.o_wb_we) ? bus.i_wb_data : {DW{1'b0}};
                    end else if (state == REQ && !bus.i_wb_stall) begin
                        bus.o_wb_stb <= 1'b0;
                        state <= WAIT;
                    end
                end
                default: begin
                    if (bus.i_rsp_ready) begin
                        bus.o_rsp_valid <= 1'b0;
                        bus.o_rsp_err <= 1'b0;
                        bus.o_rsp_timeout <= 1'b0;
                        bus.o_rsp_data <= {DW{1'b0}};
                        bus.o_cmd_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed transactions checked cycle by cycle against a transaction-level model
module tb_wb_cmd_master;
    localparam int AW = 2;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_BOTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();
    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    int n_tests = 0, n_fail = 0;
    int s_stall = 0, s_resp = 0, s_kind = K_NONE;
    logic [31:0] slv_rdata = '0;
    logic late_ack = 1'b0;
    int k = 0;
    int mode = 0, cyc_no = 0, acc_no = 0;
    int e_c = 0, e_sb = 0;
    logic e_err, e_to, e_we;
    logic [AW-1:0] e_addr;
    logic [31:0] e_data, e_wdata;

    // Slave: stall the first s_stall cycles of a bus cycle, answer in cycle s_resp (1-based)
    always @(negedge clk) begin
        k = bus.o_wb_cyc ? k + 1 : 0;
        bus.i_wb_stall = bus.o_wb_cyc && (k <= s_stall);
        bus.i_wb_ack = late_ack || (bus.o_wb_cyc && k == s_resp && (s_kind == K_ACK || s_kind == K_BOTH));
        bus.i_wb_err = bus.o_wb_cyc && k == s_resp && (s_kind == K_ERR || s_kind == K_BOTH);
        bus.i_wb_data = (k == s_resp) ? slv_rdata : 32'h5A5A5A5A;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int j;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (mode == 1) begin
                chk("idle_ready", 64'(bus.o_cmd_ready), 64'(1));
                chk("idle_bus", 64'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_rsp_valid}), 64'(0));
            end else if (mode == 2) begin
                j = cyc_no - acc_no;
                chk("cyc", 64'(bus.o_wb_cyc), 64'(j <= e_c));
                chk("stb", 64'(bus.o_wb_stb), 64'(j <= e_sb));
                chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(j > e_c));
                chk("busy_ready", 64'(bus.o_cmd_ready), 64'(0));
                if (j <= e_c)
                    chk("wb_req", 64'({bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data}), 64'({e_we, e_addr, e_wdata}));
                else begin
                    chk("rsp_flags", 64'({bus.o_rsp_err, bus.o_rsp_timeout}), 64'({e_err, e_to}));
                    chk("rsp_data", 64'(bus.o_rsp_data), 64'(e_data));
                end
            end
        end
    endtask

    task automatic set_slave(input int s, input int r, input int kind, input logic [31:0] rd);
        s_stall = s;
        s_resp = r;
        s_kind = kind;
        slv_rdata = rd;
    endtask

    task automatic start_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
        bus.i_cmd_we = we;
        bus.i_cmd_addr = a;
        bus.i_cmd_data = wd;
        bus.i_cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(output int waited);
        logic rdy, acc;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            rdy = bus.o_cmd_ready;
            @(posedge clk);
            #1;
            waited++;
            acc = rdy;
        end
        chk("accepted", 64'(acc), 64'(1));
        e_we = bus.i_cmd_we;
        e_addr = bus.i_cmd_addr;
        e_wdata = bus.i_cmd_data;
        bus.i_cmd_valid = 1'b0;
        if (s_kind != K_NONE && s_resp <= TO) begin
            e_c = s_resp;
            e_to = 1'b0;
            e_err = s_kind != K_ACK;
            e_data = (s_kind == K_ACK && !e_we) ? slv_rdata : 32'h0;
        end else begin
            e_c = TO;
            e_to = 1'b1;
            e_err = 1'b1;
            e_data = 32'h0;
        end
        e_sb = (s_stall + 1 < e_c) ? s_stall + 1 : e_c;
        acc_no = cyc_no;
        mode = 2;
    endtask

    task automatic run_rsp(input int hold, input bit late, output int lat, output logic [31:0] d, output logic [1:0] f);
        lat = 0;
        while (!bus.o_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_arrives", 64'(bus.o_rsp_valid), 64'(1));
        d = bus.o_rsp_data;
        f = {bus.o_rsp_err, bus.o_rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            late_ack = late && i == 0;
            @(posedge clk);
            #1;
        end
        late_ack = 1'b0;
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rsp_ready = 1'b0;
        mode = 1;
    endtask

    task automatic do_txn(input int s, input int r, input int kind, input logic [31:0] rd,
                          input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                          input int hold, input bit late,
                          output int lat, output logic [31:0] d, output logic [1:0] f);
        int w;
        set_slave(s, r, kind, rd);
        start_cmd(we, a, wd);
        wait_accept(w);
        run_rsp(hold, late, lat, d, f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat;
        logic [31:0] d;
        logic [1:0] f;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_we = 1'b0;
        bus.i_cmd_addr = '0;
        bus.i_cmd_data = '0;
        bus.i_rsp_ready = 1'b0;
        fork
            monitor();
        join_none
        #1;
        chk("reset_ctrl", 64'({bus.o_cmd_ready, bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_timeout,
                               bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr}), 64'(0));
        chk("reset_data", {bus.o_rsp_data, bus.o_wb_data}, 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 64'(bus.o_cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("ready_after_release", 64'(bus.o_cmd_ready), 64'(1));
        mode = 1;

        do_txn(0, 1, K_ACK, 32'h12345678, 1'b1, 2'd1, 32'h1, 0, 1'b0, lat, d, f);
        chk("t1_model_c", 64'(e_c), 64'(1));
        chk("t1_lat", 64'(lat), 64'(1));
        chk("t1_rsp", 64'({d, f}), 64'({32'h0, 2'b00}));

        do_txn(3, 6, K_ACK, 32'hDEADBEEF, 1'b0, 2'd2, 32'h0, 0, 1'b0, lat, d, f);
        chk("t2_model_sb", 64'(e_sb), 64'(4));
        chk("t2_lat", 64'(lat), 64'(6));
        chk("t2_rsp", 64'({d, f}), 64'({32'hDEADBEEF, 2'b00}));

        do_txn(0, 2, K_ERR, 32'h77, 1'b1, 2'd3, 32'hCAFE0003, 1, 1'b0, lat, d, f);
        chk("t3_lat", 64'(lat), 64'(2));
        chk("t3_rsp", 64'({d, f}), 64'({32'h0, 2'b10}));

        do_txn(0, 2, K_BOTH, 32'h99, 1'b0, 2'd0, 32'h0, 0, 1'b0, lat, d, f);
        chk("t3b_err_wins", 64'({d, f}), 64'({32'h0, 2'b10}));

        do_txn(4, 2, K_ACK, 32'h0BADF00D, 1'b0, 2'd1, 32'h0, 0, 1'b0, lat, d, f);
        chk("t3c_model_sb", 64'(e_sb), 64'(2));
        chk("t3c_ack_in_stall", 64'({d, f}), 64'({32'h0BADF00D, 2'b00}));

        do_txn(1, 0, K_NONE, 32'h0, 1'b0, 2'd2, 32'h0, 3, 1'b1, lat, d, f);
        chk("t4_model_c", 64'(e_c), 64'(8));
        chk("t4_lat", 64'(lat), 64'(8));
        chk("t4_rsp", 64'({d, f}), 64'({32'h0, 2'b11}));
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        do_txn(0, 8, K_ACK, 32'hA5A50008, 1'b0, 2'd3, 32'h0, 0, 1'b0, lat, d, f);
        chk("t4b_ack_at_limit", 64'({d, f}), 64'({32'hA5A50008, 2'b00}));
        do_txn(0, 9, K_ACK, 32'hA5A50009, 1'b0, 2'd3, 32'h0, 0, 1'b0, lat, d, f);
        chk("t4c_lat", 64'(lat), 64'(8));
        chk("t4c_ack_past_limit", 64'({d, f}), 64'({32'h0, 2'b11}));

        set_slave(0, 1, K_ACK, 32'hFFFF0000);
        start_cmd(1'b1, 2'd2, 32'h55);
        wait_accept(w);
        start_cmd(1'b0, 2'd0, 32'h0);
        run_rsp(5, 1'b0, lat, d, f);
        chk("t5a_rsp", 64'({d, f}), 64'({32'h0, 2'b00}));
        set_slave(0, 3, K_ACK, 32'h11110000);
        wait_accept(w);
        chk("t5_accept_after_hs", 64'(w), 64'(1));
        run_rsp(0, 1'b0, lat, d, f);
        chk("t5b_lat", 64'(lat), 64'(3));
        chk("t5b_rsp", 64'({d, f}), 64'({32'h11110000, 2'b00}));

        set_slave(0, 0, K_NONE, 32'h0);
        start_cmd(1'b0, 2'd1, 32'h0);
        wait_accept(w);
        @(posedge clk);
        #3;
        mode = 0;
        rst = 1'b1;
        #1;
        chk("t6_async_reset", 64'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_cmd_ready, bus.o_rsp_valid}), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_ready_low", 64'({bus.o_cmd_ready, bus.o_rsp_valid}), 64'(0));
        @(posedge clk);
        #1;
        chk("t6_ready_high", 64'({bus.o_cmd_ready, bus.o_rsp_valid}), 64'(2'b10));
        mode = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_txn(1, 3, K_ACK, 32'h1, 1'b1, 2'd1, 32'h600D, 0, 1'b0, lat, d, f);
        chk("t6_after_lat", 64'(lat), 64'(3));
        chk("t6_after_rsp", 64'({d, f}), 64'({32'h0, 2'b00}));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
